// File: rtl/uart_boot_loader_pkg.sv
// rtl/uart_boot_loader_pkg.sv - sync byte, state encoding and helpers for the UART boot loader
//
// Purpose : constants shared by the boot loader FSM.
// Macro   : LOADER_CHECKSUM_EN adds the CSUM state to the encoding.
package uart_boot_loader_pkg;

  // First byte of every download frame.
  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  // 4-bit state encodings. The CSUM code is reserved even when the
  // checksum build is off, so the other codes do not move between builds.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'h0,
    ST_LEN_LO = 4'h1,
    ST_LEN_HI = 4'h2,
    ST_DATA   = 4'h3,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM   = 4'h4,
`endif
    ST_ERR    = 4'h5
  } state_t;

  // True while a frame is being received: the core is held and the
  // inter-byte timeout runs.
  function automatic logic in_frame(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM:                       r = 1'b1;
`endif
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte address of word number idx.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - parses a UART download frame and writes 32-bit words into instruction ROM
//
// Purpose : consumes the UART RX byte stream, parses one download frame
//           (0xA5 | LEN_LO | LEN_HI | LEN*4 data bytes LSB first | [CSUM]),
//           assembles little-endian words and writes them to ROM. The core
//           is held in reset while a frame is in progress.
// Macro   : LOADER_CHECKSUM_EN - when defined, an XOR of all data bytes is
//           kept and a trailing checksum byte must match it.
// Ports   :
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous reset, active low
//   rx_valid_i     in   1   one-cycle strobe, rx_byte_i holds a new byte
//   rx_byte_i      in   8   received byte
//   rom_wr_en_o    out  1   one-cycle ROM write strobe
//   rom_wr_addr_o  out  32  ROM byte address (word aligned), held between writes
//   rom_wr_data_o  out  32  ROM write data, held between writes
//   cpu_hold_o     out  1   1 = keep core in reset
//   done_o         out  1   sticky: last frame completed OK
//   err_o          out  1   sticky: last frame aborted
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  output logic        rom_wr_en_o,
  output logic [31:0] rom_wr_addr_o,
  output logic [31:0] rom_wr_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        state_d;

  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   len_rx;      // full count as it arrives with LEN_HI
  logic [15:0]   word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_word;    // lower three bytes of the word being assembled
  logic [TW-1:0] idle_cnt;

  logic          len_ok;
  logic          last_word;
  logic          timeout;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // control strobes decoded from the FSM
  logic start_frame;
  logic len_lo_we;
  logic len_hi_we;
  logic data_we;
  logic word_done;
  logic set_done;
  logic set_err;

  assign len_rx    = {rx_byte_i, len_lo};
  assign len_ok    = (len_rx != 16'd0) && (32'(len_rx) <= MAX_WORDS);
  // word_idx advances with the write strobe, which always lands at least
  // three bytes before the next word completes, so it is current here.
  assign last_word = (word_idx == (len - 16'd1));
  // A byte arriving on the final allowed cycle still counts.
  assign timeout   = in_frame(state) && !rx_valid_i && (idle_cnt == TO_LAST);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state;
    if (timeout) begin
      state_d = ST_ERR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid_i && (rx_byte_i == LOADER_SYNC)) state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (rx_valid_i) state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          if (rx_valid_i) state_d = len_ok ? ST_DATA : ST_ERR;
        end
        ST_DATA: begin
          if (rx_valid_i && (byte_cnt == 2'd3) && last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (rx_valid_i) state_d = (rx_byte_i == csum) ? ST_IDLE : ST_ERR;
        end
`endif
        ST_ERR: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------
  always_comb begin
    start_frame = 1'b0;
    len_lo_we   = 1'b0;
    len_hi_we   = 1'b0;
    data_we     = 1'b0;
    word_done   = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;

    start_frame = (state == ST_IDLE) && rx_valid_i && (rx_byte_i == LOADER_SYNC);
    len_lo_we   = (state == ST_LEN_LO) && rx_valid_i;
    len_hi_we   = (state == ST_LEN_HI) && rx_valid_i;
    data_we     = (state == ST_DATA) && rx_valid_i;
    word_done   = data_we && (byte_cnt == 2'd3);
    // The only way from a frame state straight to IDLE is a good finish;
    // every failure passes through ERR first.
    set_done    = in_frame(state) && (state_d == ST_IDLE);
    set_err     = (state == ST_ERR);
  end

  // ---------------------------------------------------------------------
  // Datapath, status flags and write stage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo        <= '0;
      len           <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      asm_word      <= '0;
      idle_cnt      <= '0;
      rom_wr_en_o   <= 1'b0;
      rom_wr_addr_o <= '0;
      rom_wr_data_o <= '0;
      cpu_hold_o    <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      if (rx_valid_i || !in_frame(state)) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (start_frame) begin
        done_o     <= 1'b0;
        err_o      <= 1'b0;
        cpu_hold_o <= 1'b1;
      end
      if (set_done) begin
        done_o     <= 1'b1;
        cpu_hold_o <= 1'b0;
      end
      if (set_err) begin
        err_o      <= 1'b1;
        cpu_hold_o <= 1'b0;
      end

      if (rom_wr_en_o) begin
        word_idx <= word_idx + 16'd1;
      end

      if (len_lo_we) begin
        len_lo <= rx_byte_i;
      end
      if (len_hi_we) begin
        len      <= len_rx;
        word_idx <= '0;
        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end

      if (data_we) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ rx_byte_i;
`endif
        case (byte_cnt)
          2'd0:    asm_word[7:0]   <= rx_byte_i;
          2'd1:    asm_word[15:8]  <= rx_byte_i;
          2'd2:    asm_word[23:16] <= rx_byte_i;
          default: ;
        endcase
      end

      // Single-register write stage: the word is launched the cycle after
      // its fourth byte; address/data hold until the next word.
      rom_wr_en_o <= word_done;
      if (word_done) begin
        rom_wr_addr_o <= word_addr(ROM_BASE, word_idx);
        rom_wr_data_o <= {rx_byte_i, asm_word};
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader
`timescale 1ns/1ps
module tb_uart_boot_loader;

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam int unsigned MAX_WORDS   = 4096;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int          SETTLE      = TIMEOUT_CYC + 40;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_byte_i  = 8'h00;
  logic        rom_wr_en_o;
  logic [31:0] rom_wr_addr_o;
  logic [31:0] rom_wr_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  uart_boot_loader #(
    .ROM_BASE    (ROM_BASE),
    .MAX_WORDS   (MAX_WORDS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid_i    (rx_valid_i),
    .rx_byte_i     (rx_byte_i),
    .rom_wr_en_o   (rom_wr_en_o),
    .rom_wr_addr_o (rom_wr_addr_o),
    .rom_wr_data_o (rom_wr_data_o),
    .cpu_hold_o    (cpu_hold_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic        exp_hold = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicted.
  always @(negedge clk) begin
    if (rst_n && rom_wr_en_o) begin
      wr_count++;
      last_addr = rom_wr_addr_o;
      last_data = rom_wr_data_o;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", rom_wr_addr_o, rom_wr_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", rom_wr_addr_o, mon_e.addr);
        check("wr_data", rom_wr_data_o, mon_e.data);
      end
    end
  end

  task automatic end_frame(input logic ok);
    exp_done = ok;
    exp_err  = !ok;
    exp_hold = 1'b0;
  endtask

  // Frame-level model: find the sync byte, read the count, cut the payload
  // into little-endian words. Anything missing means the frame times out.
  task automatic model_frame(input byte_q_t bq);
    int          i;
    int          len;
    logic [7:0]  x;
    logic [31:0] w;
    wr_t         e;
    i = 0;
    while (i < bq.size() && bq[i] != 8'hA5) i++;
    if (i >= bq.size()) return;
    x = 8'h00;
    if (i + 2 >= bq.size()) begin
      end_frame(1'b0);
      return;
    end
    len = int'(bq[i+1]) + 256 * int'(bq[i+2]);
    if (len == 0 || len > int'(MAX_WORDS)) begin
      end_frame(1'b0);
      return;
    end
    for (int wi = 0; wi < len; wi++) begin
      int b0;
      b0 = i + 3 + 4 * wi;
      if (b0 + 3 >= bq.size()) begin
        end_frame(1'b0);
        return;
      end
      w = {bq[b0+3], bq[b0+2], bq[b0+1], bq[b0]};
      x = x ^ bq[b0] ^ bq[b0+1] ^ bq[b0+2] ^ bq[b0+3];
      e.addr = ROM_BASE + 32'(4 * wi);
      e.data = w;
      exp_q.push_back(e);
    end
`ifdef LOADER_CHECKSUM_EN
    if (i + 3 + 4 * len >= bq.size()) end_frame(1'b0);
    else end_frame(bq[i + 3 + 4 * len] == x);
`else
    end_frame(1'b1);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    @(negedge clk);
    rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input byte_q_t bq, input int gap);
    model_frame(bq);
    foreach (bq[k]) send_byte(bq[k], gap);
    repeat (SETTLE) @(negedge clk);
    check({name, "_done"}, 32'(done_o), 32'(exp_done));
    check({name, "_err"}, 32'(err_o), 32'(exp_err));
    check({name, "_hold"}, 32'(cpu_hold_o), 32'(exp_hold));
    check({name, "_pending"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wr_en"}, 32'(rom_wr_en_o), 32'd0);
    check({name, "_addr"}, rom_wr_addr_o, 32'd0);
    check({name, "_data"}, rom_wr_data_o, 32'd0);
    check({name, "_hold"}, 32'(cpu_hold_o), 32'd0);
    check({name, "_done"}, 32'(done_o), 32'd0);
    check({name, "_err"}, 32'(err_o), 32'd0);
  endtask

  byte_q_t f1;
  byte_q_t f;
  int      wc0;

  initial begin
    f1 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
    f1.push_back(8'h2A);
`endif

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two-word frame
    wc0 = wr_count;
    run_frame("t1", f1, 1);
    check("t1_nwr", wr_count - wc0, 32'd2);
    check("t1_last_addr", last_addr, 32'h0000_0004);
    check("t1_last_data", last_data, 32'hDEAD_BEEF);
    check("t1_done_lit", 32'(done_o), 32'd1);

    // 1b: same frame back to back, bytes arrive during the write strobe
    wc0 = wr_count;
    run_frame("t1b", f1, 0);
    check("t1b_nwr", wr_count - wc0, 32'd2);

    // 2: garbage before the sync byte
    wc0 = wr_count;
    f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    f.push_back(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    run_frame("t2", f, 2);
    check("t2_nwr", wr_count - wc0, 32'd1);
    check("t2_last_data", last_data, 32'h4433_2211);
    check("t2_last_addr", last_addr, ROM_BASE);

    // sync value inside the payload is plain data
    wc0 = wr_count;
    f = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h01};
`ifdef LOADER_CHECKSUM_EN
    f.push_back(8'h01);
`endif
    run_frame("tsync", f, 0);
    check("tsync_last_data", last_data, 32'h0100_A5A5);
    check("tsync_nwr", wr_count - wc0, 32'd1);

    // 3: bad lengths
    wc0 = wr_count;
    f = '{8'hA5, 8'h00, 8'h00};
    run_frame("t3a", f, 1);
    check("t3a_err_lit", 32'(err_o), 32'd1);
    f = '{8'hA5, 8'h01, 8'h10};
    run_frame("t3b", f, 1);
    check("t3b_err_lit", 32'(err_o), 32'd1);
    check("t3_nwr", wr_count - wc0, 32'd0);

    // 4: truncated frame times out after one word
    wc0 = wr_count;
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    run_frame("t4", f, 1);
    check("t4_nwr", wr_count - wc0, 32'd1);
    check("t4_err_lit", 32'(err_o), 32'd1);
    check("t4_hold_lit", 32'(cpu_hold_o), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // 5: wrong checksum
    wc0 = wr_count;
    f = f1;
    f[f.size()-1] = 8'h2B;
    run_frame("t5", f, 1);
    check("t5_nwr", wr_count - wc0, 32'd2);
    check("t5_err_lit", 32'(err_o), 32'd1);
    check("t5_done_lit", 32'(done_o), 32'd0);
`endif

    // slow but legal byte spacing must not time out
    run_frame("tslow", f1, int'(TIMEOUT_CYC) - 14);
    check("tslow_done_lit", 32'(done_o), 32'd1);

    // 6: reset in the middle of a frame
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    repeat (2) @(negedge clk);
    check("t6_hold_mid", 32'(cpu_hold_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_hold = 1'b0;
    exp_q.delete();
    @(negedge clk);
    wc0 = wr_count;
    run_frame("t6", f1, 1);
    check("t6_nwr", wr_count - wc0, 32'd2);
    check("t6_done_lit", 32'(done_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
